// File: rtl/pwm_capture_if.sv
// -----------------------------------------------------------------------------
// pwm_capture_if
//
// Avalon-MM slave bus bundle for the PWM input-capture peripheral.
//
// Signals
//   address     2   register select (0 PERIOD, 1 HIGH, 2 STATUS, 3 TIMEOUT)
//   chipselect  1   slave select
//   write_n     1   active-low write strobe
//   writedata   32  write data
//   readdata    32  zero-wait read data, driven by the slave
//
// Modports
//   master  drives the request side and samples readdata (CPU / testbench)
//   slave   receives the request side and drives readdata (pwm_capture)
// -----------------------------------------------------------------------------
interface pwm_capture_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//
// PWM input-capture peripheral. Synchronises an external PWM line, measures the
// number of clock cycles between consecutive rising edges (PERIOD) and from a
// rising edge to the following falling edge (HIGH), and exposes both through an
// Avalon-MM register file. A programmable stall timeout drops the block back to
// IDLE when no rising edge arrives in time; an interrupt is raised for a new
// capture or a timeout when enabled.
//
// Parameters
//   WIDTH        counter / register width, at most 32
//   SYNC_STAGES  synchroniser depth on pwm_in, at least 2
//
// Ports
//   clk     in   system clock
//   reset   in   synchronous, active-high reset
//   bus     --   Avalon-MM slave (pwm_capture_if.slave)
//   pwm_in  in   asynchronous PWM input
//   irq     out  level interrupt, IE & (NEW | TMO)
//
// Register map
//   0 PERIOD  RO   cycles between the last two rising edges
//   1 HIGH    RO   high time within that period
//   2 STATUS  bit0 NEW (W1C), bit1 TMO (W1C), bit2 IE (R/W), bit3 LEVEL (RO)
//   3 TIMEOUT R/W  stall limit in cycles after a rise; 0 disables it
// -----------------------------------------------------------------------------
module pwm_capture #(
    parameter int WIDTH       = 28,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    pwm_capture_if.slave  bus,
    input  logic          pwm_in,
    output logic          irq
);

    typedef enum logic {
        ST_IDLE,    // waiting for a reference rising edge
        ST_RUN      // armed: the next rise completes a period
    } state_t;

    localparam logic [1:0]       ADDR_PERIOD  = 2'd0;
    localparam logic [1:0]       ADDR_HIGH    = 2'd1;
    localparam logic [1:0]       ADDR_STATUS  = 2'd2;
    localparam logic [1:0]       ADDR_TIMEOUT = 2'd3;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    // Synchroniser and edge detect
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d1;
    logic                   lvl;
    logic                   rise;
    logic                   fall;

    // Measurement state
    state_t                 state;
    logic [WIDTH-1:0]       cnt;
    logic [WIDTH-1:0]       hi_lat;
    logic [WIDTH-1:0]       period_r;
    logic [WIDTH-1:0]       high_r;
    logic [WIDTH-1:0]       timeout_r;

    // Status bits
    logic                   sts_new;
    logic                   sts_tmo;
    logic                   sts_ie;

    // Bus decode
    logic                   wr_en;
    logic                   wr_status;
    logic                   wr_timeout;
    logic                   tmo_hit;
    logic [31:0]            rdata;

    // Only the low WIDTH bits (TIMEOUT) and bits [2:0] (STATUS) are used.
    logic                   unused_wdata;
    assign unused_wdata = ^bus.writedata;

    assign lvl  = sync_q[SYNC_STAGES-1];
    assign rise =  lvl & ~sync_d1;
    assign fall = ~lvl &  sync_d1;

    assign wr_en      = bus.chipselect & ~bus.write_n;
    assign wr_status  = wr_en && (bus.address == ADDR_STATUS);
    assign wr_timeout = wr_en && (bus.address == ADDR_TIMEOUT);

    // A stall is either the programmed limit or a counter that can no longer
    // represent the period; both abandon the current measurement.
    assign tmo_hit = ((timeout_r != '0) && (cnt == timeout_r)) || (cnt == CNT_MAX);

    // NOTE: every flop, synchroniser included, is cleared by reset; there is no
    // storage array here, so nothing is left to power up undefined.
    // NOTE: all state below uses non-blocking assignments so every branch sees
    // the pre-edge values of cnt, hi_lat and the status bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            sync_d1   <= 1'b0;
            state     <= ST_IDLE;
            cnt       <= '0;
            hi_lat    <= '0;
            period_r  <= '0;
            high_r    <= '0;
            timeout_r <= '0;
            sts_new   <= 1'b0;
            sts_tmo   <= 1'b0;
            sts_ie    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            sync_d1 <= lvl;

            // Free-running cycle counter restarted by every rise.
            if (rise) begin
                cnt <= CNT_ONE;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
            end

            // Register writes. They come before the hardware updates so that a
            // hardware set in the same cycle overrides a W1C.
            if (wr_status) begin
                sts_ie <= bus.writedata[2];
                if (bus.writedata[0]) begin
                    sts_new <= 1'b0;
                end
                if (bus.writedata[1]) begin
                    sts_tmo <= 1'b0;
                end
            end
            if (wr_timeout) begin
                timeout_r <= bus.writedata[WIDTH-1:0];
            end

            // NOTE: when a bit is both written-to-clear and set by hardware in
            // one cycle, the later non-blocking assignment below wins.
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        hi_lat <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rise) begin
                        period_r <= cnt;
                        high_r   <= hi_lat;
                        sts_new  <= 1'b1;
                        // Cleared so a period with no fall reports HIGH = 0.
                        hi_lat   <= '0;
                    end else begin
                        if (fall) begin
                            hi_lat <= cnt;
                        end
                        if (tmo_hit) begin
                            sts_tmo <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: rdata gets a default before the case so no path through this
    // block leaves it unassigned and no latch is inferred.
    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_PERIOD:  rdata = 32'(period_r);
            ADDR_HIGH:    rdata = 32'(high_r);
            ADDR_STATUS:  rdata = {28'd0, lvl, sts_ie, sts_tmo, sts_new};
            ADDR_TIMEOUT: rdata = 32'(timeout_r);
            default:      rdata = '0;
        endcase
    end

    assign bus.readdata = rdata;
    assign irq          = sts_ie & (sts_new | sts_tmo);

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
//
// Self-checking bench for pwm_capture. The reference model works purely from
// the waveform the bench itself drives: the number of clock ticks between the
// rises it generated and from a rise to its fall give the expected PERIOD and
// HIGH, and the status bits follow the documented set / W1C rules. A second
// instance with WIDTH = 8 exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_pwm_capture;

    localparam int SYNC = 2;
    // Ticks after the bench drives a rise at which the captured values are
    // visible: SYNC synchroniser edges plus the register update edge.
    localparam int CAP  = SYNC + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        pwm_a;
    logic        pwm_b;
    logic        irq_a;
    logic        irq_b;
    logic [1:0]  addr;
    logic        cs;
    logic        wr_n;
    logic [31:0] wdata;

    pwm_capture_if bus_a ();
    pwm_capture_if bus_b ();

    // Both instances see the same bus requests; only readdata is separate.
    assign bus_a.address    = addr;
    assign bus_a.chipselect = cs;
    assign bus_a.write_n    = wr_n;
    assign bus_a.writedata  = wdata;
    assign bus_b.address    = addr;
    assign bus_b.chipselect = cs;
    assign bus_b.write_n    = wr_n;
    assign bus_b.writedata  = wdata;

    pwm_capture #(.WIDTH(28), .SYNC_STAGES(SYNC)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus_a.slave),
        .pwm_in (pwm_a),
        .irq    (irq_a)
    );

    pwm_capture #(.WIDTH(8), .SYNC_STAGES(SYNC)) dut8 (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus_b.slave),
        .pwm_in (pwm_b),
        .irq    (irq_b)
    );

    always #10 clk = ~clk;

    // ---------------- bookkeeping and reference model ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    int          tick_cnt = 0;
    int          last_rise = 0;
    int          last_fall = 0;
    bit          armed;
    logic [31:0] m_period;
    logic [31:0] m_high;
    logic        m_new;
    logic        m_tmo;
    logic        m_ie;
    int          m_timeout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        armed     = 1'b0;
        m_period  = '0;
        m_high    = '0;
        m_new     = 1'b0;
        m_tmo     = 1'b0;
        m_ie      = 1'b0;
        m_timeout = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tick_cnt++;
    endtask

    task automatic bus_read(input logic [1:0] a, input bit from8, output logic [31:0] d);
        addr = a;
        cs   = 1'b1;
        wr_n = 1'b1;
        #1;
        d  = from8 ? bus_b.readdata : bus_a.readdata;
        cs = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        cs    = 1'b1;
        wr_n  = 1'b0;
        tick();
        cs    = 1'b0;
        wr_n  = 1'b1;
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d;
        bus_read(2'd2, 1'b0, d);
        check({tag, "_status"}, d & 32'h7, {29'd0, m_ie, m_tmo, m_new});
        check({tag, "_irq"}, {31'd0, irq_a}, {31'd0, m_ie & (m_new | m_tmo)});
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] d;
        bus_read(2'd0, 1'b0, d);
        check({tag, "_period"}, d, m_period);
        bus_read(2'd1, 1'b0, d);
        check({tag, "_high"}, d, m_high);
    endtask

    task automatic check_all_zero(input string tag);
        logic [31:0] d;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), 1'b0, d);
            check($sformatf("%s_addr%0d", tag, a), d, 32'd0);
        end
        check({tag, "_irq"}, {31'd0, irq_a}, 32'd0);
    endtask

    // Drives one PWM period on pwm_a starting with a rise, checking the
    // capture of the previous period. w1c_at >= 0 issues a W1C of NEW at
    // that tick index.
    task automatic run_period(input int per, input int hi, input int w1c_at);
        bit cap;
        int to_at;
        cap = armed;
        if (cap) begin
            m_period = 32'(tick_cnt - last_rise);
            m_high   = 32'(last_fall - last_rise);
        end
        armed     = 1'b1;
        last_rise = tick_cnt;
        to_at     = (m_timeout != 0) ? CAP + m_timeout : -1;
        for (int i = 0; i < per; i++) begin
            pwm_a = (i < hi);
            if (i == hi) last_fall = tick_cnt;
            cs   = 1'b0;
            wr_n = 1'b1;
            if (i == w1c_at) check_status("pre_set");
            if (i == CAP) begin
                if (cap) m_new = 1'b1;
                check_regs(cap ? "capture" : "rearm");
                check_status(cap ? "capture" : "rearm");
            end
            if (i == CAP + 2) begin
                m_new = 1'b0;
                check_status("after_w1c");
            end
            if (armed && to_at > 0 && i == to_at - 1) check_status("pre_tmo");
            if (armed && to_at > 0 && i == to_at) begin
                m_tmo = 1'b1;
                armed = 1'b0;
                check_status("tmo");
                check_regs("tmo_keep");
            end
            if (i == w1c_at || i == CAP + 1) begin
                addr  = 2'd2;
                wdata = {29'd0, m_ie, 1'b0, 1'b1};
                cs    = 1'b1;
                wr_n  = 1'b0;
            end
            tick();
        end
        cs   = 1'b0;
        wr_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        int          per;
        int          hi;

        reset = 1'b1;
        pwm_a = 1'b0;
        pwm_b = 1'b0;
        addr  = 2'd0;
        cs    = 1'b0;
        wr_n  = 1'b1;
        wdata = '0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;

        // Reset state of both instances.
        check_all_zero("reset");
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), 1'b1, d);
            check($sformatf("reset8_addr%0d", a), d, 32'd0);
        end
        check("reset8_irq", {31'd0, irq_b}, 32'd0);

        // WIDTH=8 instance: a rise arms it, holding high saturates cnt at 255.
        // The internal rise is seen at tick SYNC, so cnt = 255 at SYNC+255 and
        // TMO is visible one tick later.
        for (int i = 0; i < SYNC + 262; i++) begin
            pwm_b = 1'b1;
            if (i == SYNC + 255) begin
                bus_read(2'd2, 1'b1, d);
                check("sat_pre_tmo", d & 32'h2, 32'h0);
            end
            if (i == SYNC + 256) begin
                bus_read(2'd2, 1'b1, d);
                check("sat_tmo", d & 32'h2, 32'h2);
                check("sat_level", d & 32'h8, 32'h8);
                bus_read(2'd0, 1'b1, d);
                check("sat_period", d, 32'd0);
            end
            tick();
        end
        pwm_b = 1'b0;

        // Directed 100/30 and 250/200 periods with the interrupt enabled.
        bus_write(2'd2, 32'h4);
        m_ie = 1'b1;
        repeat (3) run_period(100, 30, -1);
        run_period(250, 200, -1);
        run_period(250, 200, SYNC);   // W1C of NEW in the cycle NEW sets

        // Stall timeout: 500 cycles after the last rise with the line low.
        bus_write(2'd3, 32'd500);
        m_timeout = 500;
        run_period(100, 30, -1);
        run_period(600, 30, -1);
        bus_write(2'd2, {29'd0, m_ie, 2'b10});
        m_tmo = 1'b0;
        bus_write(2'd3, 32'd0);
        m_timeout = 0;
        run_period(100, 30, -1);      // re-arm only
        run_period(80, 20, -1);       // captures

        // Randomised periods.
        for (int k = 0; k < 8; k++) begin
            hi  = int'($urandom_range(60, 8));
            per = hi + int'($urandom_range(80, 8));
            run_period(per, hi, -1);
        end

        // Reset in the middle of a period.
        pwm_a = 1'b1;
        repeat (20) tick();
        pwm_a = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        model_reset();
        check_all_zero("midreset");
        run_period(90, 40, -1);       // first rise only re-arms
        run_period(70, 25, -1);
        run_period(50, 10, -1);

        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
